// File: rtl/ctrl_pipe.sv
// Control-word pipeline from ID into a DEPTH-stage chain with bubble insertion, flush squash and
// delay-slot nullification. Define CTRL_PIPE_PERF_EN to build the saturating bubble/squash counters.
module ctrl_pipe #(
    parameter int            CW     = 23,
    parameter int            DEPTH  = 3,
    parameter logic [CW-1:0] BUBBLE = CW'(23'h000040)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CW-1:0]              id_ctrl,
    input  logic                       id_valid,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       br_taken,
    input  logic                       nullify,
    output logic [DEPTH*CW-1:0]        stage_ctrl,
    output logic [DEPTH-1:0]           stage_vld,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic                       nul_pend,
    output logic [15:0]                bubble_cnt,
    output logic [15:0]                squash_cnt
);
    localparam int OW = $clog2(DEPTH+1);

    typedef enum logic {RUN, PEND} state_t;

    // Handshake: there is no back-pressure into ID; a word is accepted on an edge
    // exactly when stage 0 loads it with valid=1, and stall only bubbles stage 0.
    state_t                   state;
    logic [DEPTH-1:0][CW-1:0] stages;
    logic [CW-1:0]            s0_ctrl;
    logic                     s0_vld;
    logic                     is_bubble;
    logic                     is_squash;
    logic                     squash_cond;
    logic [OW-1:0]            occ_c;

    assign squash_cond = ((state == RUN) && br_taken && nullify) || (state == PEND);

    always_comb begin
        s0_ctrl   = BUBBLE;
        s0_vld    = 1'b0;
        is_bubble = 1'b0;
        is_squash = 1'b0;
        if (flush) begin
            is_squash = 1'b1;
        end else if (stall) begin
            is_bubble = 1'b1;
        end else if (squash_cond) begin
            is_squash = 1'b1;
        end else if (!id_valid) begin
            is_bubble = 1'b1;
        end else begin
            s0_ctrl = id_ctrl;
            s0_vld  = 1'b1;
        end
    end

    // Nullify FSM: a taken nullifying branch seen under stall defers the
    // delay-slot squash until the first unstalled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (br_taken && nullify && stall && !flush)
                        state <= PEND;
                end
                PEND: begin
                    if (flush || !stall)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign nul_pend = (state == PEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++)
                stages[k] <= BUBBLE;
            stage_vld <= '0;
        end else begin
            stages[0] <= s0_ctrl;
            for (int k = 1; k < DEPTH; k++)
                stages[k] <= stages[k-1];
            stage_vld <= {stage_vld[DEPTH-2:0], s0_vld};
        end
    end

    assign stage_ctrl = stages;

    always_comb begin
        occ_c = '0;
        for (int i = 0; i < DEPTH; i++)
            occ_c = occ_c + OW'(stage_vld[i]);
    end

    assign occ  = occ_c;
    assign busy = |stage_vld;

`ifdef CTRL_PIPE_PERF_EN
    logic [15:0] bub_q;
    logic [15:0] sq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bub_q <= 16'h0000;
            sq_q  <= 16'h0000;
        end else begin
            if (is_bubble && (bub_q != 16'hFFFF))
                bub_q <= bub_q + 16'h0001;
            if (is_squash && (sq_q != 16'hFFFF))
                sq_q <= sq_q + 16'h0001;
        end
    end

    assign bubble_cnt = bub_q;
    assign squash_cnt = sq_q;
`else
    logic unused_perf;
    assign unused_perf = is_bubble ^ is_squash;
    assign bubble_cnt  = 16'h0000;
    assign squash_cnt  = 16'h0000;
`endif

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-word pipeline for the PA-RISC PPU. It sits between the ID-stage decoder and the EX/MEM/WB datapath. It carries each decoded control word down a DEPTH-stage register chain, with valid bits alongside. It inserts bubbles on hazard stalls, squashes on flush, and applies branch delay-slot nullification through a small state machine.

## Interface
Parameters:
- CW, 23: control-word width; bits above 22 pass through untouched.
- DEPTH, 3: number of post-ID stages (EX, MEM, WB, ...); legal range 2..6.
- BUBBLE, 23'h000040: inserted word; NOP with ID_SR=2'b10 and every other field zero.

Control-word bit map (CW=23):
- SH[22], RD_F[21:20], BL[19], SOH_OP[18:16], ALU_OP[15:12]
- RAM_CTRL[11:8], L[7], ID_SR[6:5], RF_LE[4], PSW_EN[3], CO_EN[2], COMB[1:0]

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_ctrl  in  CW  decoded control word of the ID-stage instruction.
- id_valid  in  1  ID holds a real instruction.
- stall  in  1  hazard stall; ID is held upstream.
- flush  in  1  squash the ID instruction and cancel a pending nullify.
- br_taken  in  1  branch in EX resolved taken this cycle.
- nullify  in  1  taken branch nullifies its delay slot; sampled only with br_taken.
- stage_ctrl  out  DEPTH*CW  stage k at [k*CW +: CW]; k=0 is EX.
- stage_vld  out  DEPTH  per-stage valid.
- busy  out  1  |stage_vld.
- occ  out  $clog2(DEPTH+1)  count of valid stages.
- nul_pend  out  1  FSM in PEND.
- bubble_cnt, squash_cnt  out  16 each  performance counters (see Configuration).

## Operation
- Stages 1..DEPTH-1 always advance from stage k-1 on every edge; stall never holds them.
- Stage 0 loads from the first matching row below, highest priority first:
  - flush: BUBBLE, vld=0. FSM goes to RUN.
  - stall: BUBBLE, vld=0. The ID word is re-presented upstream next cycle.
  - squash condition: BUBBLE, vld=0, counted as a squash. The condition is (RUN and br_taken and nullify) or PEND.
  - !id_valid: BUBBLE, vld=0.
  - otherwise: id_ctrl, vld=1.
- Nullify FSM, states RUN and PEND:
  - RUN to PEND: br_taken and nullify and stall and !flush. The delay slot is still in ID, so its squash is deferred.
  - PEND to RUN: the first edge with !stall, which squashes the delay slot, or any flush.
  - br_taken with nullify=0 causes no state change.
  - br_taken while in PEND is ignored; a delay slot cannot hold a taken branch.
- An invalid stage always carries BUBBLE. The datapath therefore never sees RF_LE, PSW_EN or RAM_CTRL write bits from a squashed instruction.
- occ is the popcount of stage_vld. busy = (occ != 0).

## Timing
- Reset (rst_n low, async): every stage_ctrl slice = BUBBLE, stage_vld = 0, FSM = RUN, nul_pend = 0, occ = 0, busy = 0, counters = 0.
- Latency: an id_ctrl accepted at edge t appears at stage k after edge t+k, i.e. stage 0 is valid in the cycle after acceptance.
- All outputs are registered or decoded from registers only. No combinational input-to-output path exists.
- Simultaneous events:
  - flush with stall, or flush with br_taken/nullify: flush wins and the FSM ends in RUN.
  - stall with squash condition in RUN: go to PEND; the stall-bubble counts as a bubble, not a squash.
- Reset asserted mid-operation clears all in-flight words immediately. No drain occurs.

## Configuration
- CTRL_PIPE_PERF_EN defined:
  - bubble_cnt increments on each stall or !id_valid bubble into stage 0.
  - squash_cnt increments on each flush or nullify squash into stage 0.
  - Both saturate at 16'hFFFF.
- Not defined: both outputs are tied to 16'h0000 and no counter registers exist.

## Test plan
- Reset then stream ADD word 23'h500419 with id_valid=1 for 4 cycles -> stage_vld ramps 001, 011, 111; stage 2 shows 23'h500419 three cycles after the first acceptance; occ=3.
- Stall for 2 cycles mid-stream -> two BUBBLE words (23'h000040, vld=0) travel EX to WB; bubble_cnt=2 (macro on); occ dips to 1 then recovers.
- br_taken=1, nullify=1, stall=0 -> next stage-0 word is BUBBLE, squash_cnt=1, FSM stays RUN; with nullify=0 the delay slot enters valid.
- br_taken=1, nullify=1, stall=1 for 3 cycles -> nul_pend=1 for those cycles; on the first unstalled edge the delay slot is squashed and nul_pend returns to 0.
- Same as the previous case plus flush in the second stall cycle -> nul_pend clears at that edge; after the stall the next instruction enters valid.
- Assert rst_n=0 asynchronously with 3 valid stages -> immediately stage_vld=0, all slices = BUBBLE, counters=0; macro off -> counters read 0 throughout.
